serial_word_rx: RTL and testbench

- Upstream stage of the 7-segment display path.
- Receives an asynchronous serial frame on one wire: start bit, 5 data bits, parity bit, stop bit.
- Deframes it and presents b1..b5 and b_par as stable registered levels to the display/parity-check stage.
- Holds the last good word until the next good frame arrives.

---
 rtl/serial_word_pkg.sv | 38 +++
 rtl/sync_2ff.sv | 34 +++
 rtl/serial_word_rx.sv | 176 +++++++++++++++++
 tb/tb_serial_word_rx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_word_pkg.sv
// ============================================================================
// Module : serial_word_pkg
// Brief  : Shared types, constants and helpers for the serial word receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_word_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int DATA_BITS = 5;

  // Minimum of 1 so a timer vector is never zero-width.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic parity_check(input logic [DATA_BITS-1:0] data,
                                        input logic                 par,
                                        input logic                 odd);
    return (((^data) ^ par) == odd);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchroniser with configurable reset value.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/serial_word_rx.sv
// ============================================================================
// Module : serial_word_rx
// Brief  : Deframes start/5 data/parity/stop serial frames into held levels.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_word_rx
  import serial_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_serial,
  output logic b1,
  output logic b2,
  output logic b3,
  output logic b4,
  output logic b5,
  output logic b_par,
  output logic parity_ok,
  output logic word_valid,
  output logic frame_err,
  output logic busy
);

  localparam int c_tw = clog2(CLKS_PER_BIT);
  localparam logic [c_tw-1:0] c_half_m1 = c_tw'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_tw-1:0] c_full_m1 = c_tw'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      c_last_idx = 3'(DATA_BITS - 1);

  localparam logic [2:0] c_st_idle   = IDLE;
  localparam logic [2:0] c_st_start  = START;
  localparam logic [2:0] c_st_data   = DATA;
  localparam logic [2:0] c_st_parity = PARITY;
  localparam logic [2:0] c_st_stop   = STOP;

  logic w_rst_n;
  logic w_rx_s;

  logic [2:0]           r_state;
  logic [c_tw-1:0]      r_timer;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_hold;
  logic                 r_stop_fire;
  logic                 r_stop_bit;

  logic [DATA_BITS-1:0] r_word;
  logic                 r_b_par;
  logic                 r_parity_ok;
  logic                 r_word_valid;
  logic                 r_frame_err;

  // Reset asserts asynchronously, releases two clocks after rst_n rises.
  sync_2ff #(.RESET_VAL(1'b0)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (w_rst_n)
  );

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (w_rst_n),
    .d     (rx_serial),
    .q     (w_rx_s)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= c_st_idle;
      r_timer     <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_par_hold  <= 1'b0;
      r_stop_fire <= 1'b0;
      r_stop_bit  <= 1'b0;
    end else begin
      r_stop_fire <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (!w_rx_s) begin
            r_state <= c_st_start;
            r_timer <= '0;
          end
        end
        c_st_start: begin
          if (r_timer == c_half_m1) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_state <= w_rx_s ? c_st_idle : c_st_data;
          end else begin
            r_timer <= r_timer + c_tw'(1);
          end
        end
        c_st_data: begin
          if (r_timer == c_full_m1) begin
            r_timer        <= '0;
            r_shift[r_idx] <= w_rx_s;
            if (r_idx == c_last_idx) begin
              r_state <= c_st_parity;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_timer <= r_timer + c_tw'(1);
          end
        end
        c_st_parity: begin
          if (r_timer == c_full_m1) begin
            r_timer    <= '0;
            r_par_hold <= w_rx_s;
            r_state    <= c_st_stop;
          end else begin
            r_timer <= r_timer + c_tw'(1);
          end
        end
        c_st_stop: begin
          if (r_timer == c_full_m1) begin
            r_timer     <= '0;
            r_stop_fire <= 1'b1;
            r_stop_bit  <= w_rx_s;
            r_state     <= c_st_idle;
          end else begin
            r_timer <= r_timer + c_tw'(1);
          end
        end
        default: begin
          r_state <= c_st_idle;
          r_timer <= '0;
        end
      endcase
    end
  end

  // Held word only changes on a completed frame with a good stop bit.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_word       <= '0;
      r_b_par      <= 1'b0;
      r_parity_ok  <= ~PARITY_ODD;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_stop_fire) begin
        if (r_stop_bit) begin
          r_word       <= r_shift;
          r_b_par      <= r_par_hold;
          r_parity_ok  <= parity_check(r_shift, r_par_hold, PARITY_ODD);
          r_word_valid <= 1'b1;
        end else begin
          r_frame_err  <= 1'b1;
        end
      end
    end
  end

  assign b1         = r_word[0];
  assign b2         = r_word[1];
  assign b3         = r_word[2];
  assign b4         = r_word[3];
  assign b5         = r_word[4];
  assign b_par      = r_b_par;
  assign parity_ok  = r_parity_ok;
  assign word_valid = r_word_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_serial_word_rx.sv
// ============================================================================
// Module : tb_serial_word_rx
// Brief  : Directed self-checking bench for serial_word_rx.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_word_rx;

  logic clk;
  logic rst_n;
  logic rx_serial;
  logic b1, b2, b3, b4, b5, b_par, parity_ok, word_valid, frame_err, busy;

  int n_cmp;
  int n_bad;

  int wv_cnt, wv_at, fe_cnt, fe_at;
  logic hold_bad;
  logic both_bad;

  serial_word_rx #(.CLKS_PER_BIT(16), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_serial  (rx_serial),
    .b1         (b1),
    .b2         (b2),
    .b3         (b3),
    .b4         (b4),
    .b5         (b5),
    .b_par      (b_par),
    .parity_ok  (parity_ok),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d = {b1,b2,b3,b4,b5}; pulse expected 124 negedges after the start edge is driven.
  task automatic send_frame(input logic [4:0] d, input logic par, input logic stop);
    logic       bits [0:7];
    logic [6:0] snap;
    int         k;
    bits[0] = 1'b0;
    bits[1] = d[4];
    bits[2] = d[3];
    bits[3] = d[2];
    bits[4] = d[1];
    bits[5] = d[0];
    bits[6] = par;
    bits[7] = stop;
    snap     = {b1, b2, b3, b4, b5, b_par, parity_ok};
    wv_cnt   = 0; wv_at = -1; fe_cnt = 0; fe_at = -1;
    hold_bad = 1'b0; both_bad = 1'b0;
    k = 0;
    for (int b = 0; b < 8; b++) begin
      rx_serial = bits[b];
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        k++;
        if (word_valid) begin wv_cnt++; wv_at = k; end
        if (frame_err)  begin fe_cnt++; fe_at = k; end
        if (word_valid && frame_err) both_bad = 1'b1;
        if (k < 124 && {b1, b2, b3, b4, b5, b_par, parity_ok} !== snap) hold_bad = 1'b1;
      end
    end
    rx_serial = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx_serial = ~rx_serial;
    end
    rx_serial = 1'b1;
    @(negedge clk);
    n_cmp++; if ({b1, b2, b3, b4, b5, b_par} !== 6'b0) begin n_bad++; $display("FAIL reset_word got=%b exp=000000", {b1, b2, b3, b4, b5, b_par}); end
    n_cmp++; if (parity_ok !== 1'b1) begin n_bad++; $display("FAIL reset_parity_ok got=%b exp=1", parity_ok); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_word_valid got=%b exp=0", word_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_frame;
    send_frame(5'b10110, 1'b1, 1'b1);
    n_cmp++; if (wv_cnt !== 1 || wv_at !== 124) begin n_bad++; $display("FAIL good_pulse got cnt=%0d at=%0d exp cnt=1 at=124", wv_cnt, wv_at); end
    n_cmp++; if (fe_cnt !== 0) begin n_bad++; $display("FAIL good_no_ferr got=%0d exp=0", fe_cnt); end
    n_cmp++; if ({b1, b2, b3, b4, b5} !== 5'b10110) begin n_bad++; $display("FAIL good_word got=%b exp=10110", {b1, b2, b3, b4, b5}); end
    n_cmp++; if (b_par !== 1'b1 || parity_ok !== 1'b1) begin n_bad++; $display("FAIL good_parity got par=%b ok=%b exp par=1 ok=1", b_par, parity_ok); end
    n_cmp++; if (hold_bad !== 1'b0 || both_bad !== 1'b0) begin n_bad++; $display("FAIL good_hold got hold=%b both=%b exp 0 0", hold_bad, both_bad); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL good_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_parity_err;
    send_frame(5'b10110, 1'b0, 1'b1);
    n_cmp++; if (wv_cnt !== 1 || wv_at !== 124) begin n_bad++; $display("FAIL perr_pulse got cnt=%0d at=%0d exp cnt=1 at=124", wv_cnt, wv_at); end
    n_cmp++; if ({b1, b2, b3, b4, b5} !== 5'b10110) begin n_bad++; $display("FAIL perr_word got=%b exp=10110", {b1, b2, b3, b4, b5}); end
    n_cmp++; if (b_par !== 1'b0) begin n_bad++; $display("FAIL perr_b_par got=%b exp=0", b_par); end
    n_cmp++; if (parity_ok !== 1'b0) begin n_bad++; $display("FAIL perr_parity_ok got=%b exp=0", parity_ok); end
  endtask

  task automatic test_back_to_back_frame_err;
    send_frame(5'b10110, 1'b1, 1'b1);
    n_cmp++; if (wv_cnt !== 1 || parity_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_first got cnt=%0d ok=%b exp cnt=1 ok=1", wv_cnt, parity_ok); end
    send_frame(5'b01010, 1'b0, 1'b0);
    n_cmp++; if (fe_cnt !== 1 || fe_at !== 124) begin n_bad++; $display("FAIL ferr_pulse got cnt=%0d at=%0d exp cnt=1 at=124", fe_cnt, fe_at); end
    n_cmp++; if (wv_cnt !== 0) begin n_bad++; $display("FAIL ferr_no_valid got=%0d exp=0", wv_cnt); end
    n_cmp++; if ({b1, b2, b3, b4, b5, b_par, parity_ok} !== 7'b1011011) begin n_bad++; $display("FAIL ferr_held got=%b exp=1011011", {b1, b2, b3, b4, b5, b_par, parity_ok}); end
    n_cmp++; if (hold_bad !== 1'b0) begin n_bad++; $display("FAIL ferr_hold got=%b exp=0", hold_bad); end
    // Trailing low stop bit looks like a new start; let it be rejected.
    repeat (30) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_glitch;
    int   pulses;
    logic saw_busy;
    pulses = 0; saw_busy = 1'b0;
    rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    rx_serial = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (word_valid || frame_err) pulses++;
    end
    n_cmp++; if (saw_busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_seen got=%b exp=1", saw_busy); end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL glitch_pulses got=%0d exp=0", pulses); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_after got=%b exp=0", busy); end
    n_cmp++; if ({b1, b2, b3, b4, b5, b_par, parity_ok} !== 7'b1011011) begin n_bad++; $display("FAIL glitch_held got=%b exp=1011011", {b1, b2, b3, b4, b5, b_par, parity_ok}); end
  endtask

  task automatic test_reset_mid_frame;
    logic busy_before;
    rx_serial = 1'b0;
    repeat (16) @(negedge clk);
    rx_serial = 1'b1;
    repeat (56) @(negedge clk);
    busy_before = busy;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy_before !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got=%b exp=1", busy_before); end
    n_cmp++; if ({b1, b2, b3, b4, b5, b_par, parity_ok} !== 7'b0000001) begin n_bad++; $display("FAIL mid_reset_outputs got=%b exp=0000001", {b1, b2, b3, b4, b5, b_par, parity_ok}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(5'b00001, 1'b1, 1'b1);
    n_cmp++; if (wv_cnt !== 1 || wv_at !== 124) begin n_bad++; $display("FAIL mid_after_pulse got cnt=%0d at=%0d exp cnt=1 at=124", wv_cnt, wv_at); end
    n_cmp++; if ({b1, b2, b3, b4, b5, b_par, parity_ok} !== 7'b0000111) begin n_bad++; $display("FAIL mid_after_word got=%b exp=0000111", {b1, b2, b3, b4, b5, b_par, parity_ok}); end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    rx_serial = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_parity_err();
    test_back_to_back_frame_err();
    test_glitch();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
